// File: rtl/demux_1x2_64line_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1x2_64line_buf_pkg
//  Brief    : Shared widths, lane indices and helpers for the 1:2 word demux.
//  Revision : 1.0  initial release
// ============================================================================
package demux_1x2_64line_buf_pkg;

   localparam int W_DEFAULT     = 64;
   localparam int CNT_W_DEFAULT = 16;
   localparam int NUM_LANES     = 2;
   localparam int LANE0         = 0;
   localparam int LANE1         = 1;

   typedef logic lane_t;

   // A one-entry buffer can take a word if it is empty or being drained now.
   function automatic logic lane_free(input logic valid, input logic ready);
      return !valid || ready;
   endfunction

endpackage
`default_nettype wire

// File: rtl/demux_1x2_64line_buf_lane.sv
`default_nettype none
// ============================================================================
//  Module   : demux_lane_buf
//  Brief    : One-entry valid/ready output register with accepted-word counter.
//  Revision : 1.0  initial release
// ============================================================================
module demux_lane_buf
   import demux_1x2_64line_buf_pkg::*;
#(
   parameter int W     = W_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [W-1:0]     wr_data,
   input  logic             rd_ready,
   output logic [W-1:0]     out_data,
   output logic             out_valid,
   output logic             free,
   output logic [CNT_W-1:0] count
);

   logic [W-1:0]     r_data;
   logic             r_valid;
   logic [CNT_W-1:0] r_count;

   assign free      = lane_free(r_valid, rd_ready);
   assign out_data  = r_data;
   assign out_valid = r_valid;
   assign count     = r_count;

   // wr_en is only raised while free, so a write may overlap a drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_count <= '0;
      end else if (wr_en) begin
         r_data  <= wr_data;
         r_valid <= 1'b1;
         r_count <= r_count + 1'b1;
      end else if (r_valid && rd_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/demux_1x2_64line_buf.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1x2_64line_buf
//  Brief    : Registered 1:2 word demux, lane chosen by s or by alternation.
//  Revision : 1.0  initial release
// ============================================================================
module demux_1x2_64line_buf
   import demux_1x2_64line_buf_pkg::*;
#(
   parameter int W     = W_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             alt_mode,
   input  logic             s,
   output logic [W-1:0]     out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [W-1:0]     out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   logic                 r_toggle;
   lane_t                w_tgt;
   logic                 w_accept;
   logic [NUM_LANES-1:0] w_free;
   logic [NUM_LANES-1:0] w_lane_ready;
   logic [NUM_LANES-1:0] w_lane_valid;
   logic [W-1:0]         w_lane_data  [NUM_LANES];
   logic [CNT_W-1:0]     w_lane_count [NUM_LANES];

   assign w_tgt    = alt_mode ? r_toggle : s;
   // Strict in-order steering: only the target lane's state gates input.
   assign in_ready = w_free[w_tgt];
   assign w_accept = in_valid && in_ready;

   assign w_lane_ready[LANE0] = out0_ready;
   assign w_lane_ready[LANE1] = out1_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_toggle <= 1'b0;
      end else if (w_accept && alt_mode) begin
         r_toggle <= ~r_toggle;
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      demux_lane_buf #(
         .W     (W),
         .CNT_W (CNT_W)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .wr_en     (w_accept && (w_tgt == 1'(i))),
         .wr_data   (in_data),
         .rd_ready  (w_lane_ready[i]),
         .out_data  (w_lane_data[i]),
         .out_valid (w_lane_valid[i]),
         .free      (w_free[i]),
         .count     (w_lane_count[i])
      );
   end

   assign out0_data  = w_lane_data[LANE0];
   assign out0_valid = w_lane_valid[LANE0];
   assign cnt0       = w_lane_count[LANE0];
   assign out1_data  = w_lane_data[LANE1];
   assign out1_valid = w_lane_valid[LANE1];
   assign cnt1       = w_lane_count[LANE1];

endmodule
`default_nettype wire

// File: tb/tb_demux_1x2_64line_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_1x2_64line_buf
//  Brief    : Self-checking bench: directed scenarios plus random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_1x2_64line_buf;

   localparam int W     = 64;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [W-1:0]     in_data;
   logic             in_valid;
   logic             in_ready;
   logic             alt_mode;
   logic             s;
   logic [W-1:0]     out0_data;
   logic             out0_valid;
   logic [W-1:0]     out1_data;
   logic             out1_valid;
   logic [1:0]       ordy;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   int checks = 0;
   int errors = 0;

   demux_1x2_64line_buf #(.W(W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alt_mode   (alt_mode),
      .s          (s),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (ordy[0]),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (ordy[1]),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: per-lane occupancy/data/count plus an ordered queue of words
   // owed to each consumer.
   logic [1:0]  mv;
   logic [63:0] md [2];
   logic [3:0]  mc [2];
   logic        mtog;
   logic [63:0] q0 [$];
   logic [63:0] q1 [$];

   always @(posedge clk or posedge rst) begin
      int  t;
      logic acc;
      if (rst) begin
         mv = 2'b00; md[0] = '0; md[1] = '0; mc[0] = '0; mc[1] = '0; mtog = 1'b0;
         q0.delete(); q1.delete();
      end else begin
         t   = alt_mode ? int'(mtog) : int'(s);
         acc = in_valid && (!mv[t] || ordy[t]);
         for (int n = 0; n < 2; n++) begin
            if (acc && t == n) begin
               md[n] = in_data; mv[n] = 1'b1; mc[n] = mc[n] + 4'd1;
               if (n == 0) q0.push_back(in_data); else q1.push_back(in_data);
            end else if (mv[n] && ordy[n]) begin
               mv[n] = 1'b0;
            end
         end
         if (acc && alt_mode) mtog = ~mtog;
      end
   end

   always @(negedge clk) begin
      int t;
      logic [63:0] e;
      t = alt_mode ? int'(mtog) : int'(s);
      chk("in_ready",   in_ready,   !mv[t] || ordy[t]);
      chk("out0_valid", out0_valid, mv[0]);
      chk("out0_data",  out0_data,  md[0]);
      chk("out1_valid", out1_valid, mv[1]);
      chk("out1_data",  out1_data,  md[1]);
      chk("cnt0",       cnt0,       mc[0]);
      chk("cnt1",       cnt1,       mc[1]);
      if (!rst && out0_valid && ordy[0]) begin
         if (q0.size() == 0) chk("lane0_order_underflow", 1, 0);
         else begin e = q0.pop_front(); chk("lane0_order", out0_data, e); end
      end
      if (!rst && out1_valid && ordy[1]) begin
         if (q1.size() == 0) chk("lane1_order_underflow", 1, 0);
         else begin e = q1.pop_front(); chk("lane1_order", out1_data, e); end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_data = '0; in_valid = 1'b0; alt_mode = 1'b0; s = 1'b0; ordy = 2'b00;
      tick; tick;
      rst = 1'b0;
      #1;
      chk("rst_out0_valid", out0_valid, 0);
      chk("rst_out1_valid", out1_valid, 0);
      chk("rst_cnt0", cnt0, 0);
      chk("rst_out1_data", out1_data, 0);
      tick;

      // Alternation with both consumers ready
      alt_mode = 1'b1; ordy = 2'b11; in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_data = 64'(i);
         #1 chk("alt_in_ready", in_ready, 1);
         tick;
         if (i % 2 == 1) begin
            chk("alt_out0_data", out0_data, 64'(i));
            chk("alt_out0_valid", out0_valid, 1);
         end else begin
            chk("alt_out1_data", out1_data, 64'(i));
            chk("alt_out1_valid", out1_valid, 1);
         end
      end
      in_valid = 1'b0;
      chk("alt_cnt0", cnt0, 2);
      chk("alt_cnt1", cnt1, 2);
      tick;

      // Stalled lane 1 holds its word and blocks input
      alt_mode = 1'b0; s = 1'b1; ordy = 2'b01; in_valid = 1'b1;
      in_data = 64'hAAAA_5555_0000_FFFF;
      tick;
      in_data = 64'h1234_5678_9ABC_DEF0;
      #1;
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out1_data", out1_data, 64'hAAAA_5555_0000_FFFF);
      chk("hold_out0_valid", out0_valid, 0);
      tick;
      chk("hold2_out1_data", out1_data, 64'hAAAA_5555_0000_FFFF);
      chk("hold2_out1_valid", out1_valid, 1);

      // Drain and load in the same cycle
      ordy = 2'b11;
      #1 chk("thru_in_ready", in_ready, 1);
      tick;
      ordy = 2'b01; in_valid = 1'b0;
      chk("thru_out1_data", out1_data, 64'h1234_5678_9ABC_DEF0);
      chk("thru_out1_valid", out1_valid, 1);

      // Toggle points at stalled lane 1 while lane 0 is empty
      alt_mode = 1'b1; s = 1'b0; in_valid = 1'b1; in_data = 64'h55;
      tick;
      in_valid = 1'b0;
      tick;
      in_valid = 1'b1; in_data = 64'h66;
      #1;
      chk("strict_in_ready", in_ready, 0);
      chk("strict_out0_valid", out0_valid, 0);
      tick;
      chk("strict_out1_data", out1_data, 64'h1234_5678_9ABC_DEF0);
      chk("strict_out0_valid2", out0_valid, 0);
      ordy = 2'b11;
      #1 chk("strict_in_ready2", in_ready, 1);
      tick;
      chk("strict_out1_new", out1_data, 64'h66);
      chk("strict_out1_valid", out1_valid, 1);
      in_valid = 1'b0;
      tick;

      // Asynchronous reset with both lanes full
      ordy = 2'b00; in_valid = 1'b1; in_data = 64'h77;
      tick;
      in_data = 64'h88;
      tick;
      in_valid = 1'b0;
      chk("full_out0_valid", out0_valid, 1);
      chk("full_out1_valid", out1_valid, 1);
      rst = 1'b1;
      #1;
      chk("arst_out0_valid", out0_valid, 0);
      chk("arst_out1_valid", out1_valid, 0);
      chk("arst_cnt0", cnt0, 0);
      chk("arst_cnt1", cnt1, 0);
      chk("arst_out0_data", out0_data, 0);
      tick;
      rst = 1'b0;
      tick;

      // Counter wrap: 17 words into lane 0 with a 4-bit counter
      alt_mode = 1'b0; s = 1'b0; ordy = 2'b11; in_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_data = 64'(100 + i);
         tick;
      end
      in_valid = 1'b0;
      chk("wrap_cnt0", cnt0, 1);
      chk("wrap_cnt1", cnt1, 0);
      chk("wrap_out0_data", out0_data, 64'd116);
      tick;

      // Random traffic against the reference
      for (int i = 0; i < 800; i++) begin
         rst      = ($urandom_range(0, 199) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = {$urandom, $urandom};
         if ($urandom_range(0, 15) == 0) alt_mode = ~alt_mode;
         s        = 1'($urandom_range(0, 1));
         ordy[0]  = ($urandom_range(0, 9) < 7);
         ordy[1]  = ($urandom_range(0, 9) < 6);
         tick;
      end
      rst = 1'b0; in_valid = 1'b0;
      tick; tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
